trace_req_sequencer: RTL and testbench

Converts the byte stream produced by the SD-card file reader (contents of the cache trace file) into a queue of memory requests for the LRU cache model. It parses ASCII trace lines of the form `<op> <hex address>`, buffers decoded requests in a small FIFO, and issues them to the cache over a valid/ready handshake. It also reports progress and sticky error flags to the board-level LEDs.

---
 rtl/trace_pkg.sv | 46 ++++
 rtl/trace_fifo.sv | 58 +++++
 rtl/trace_req_sequencer.sv | 175 +++++++++++++++++
 tb/tb_trace_req_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared constants, parser state type and ASCII helpers for the trace request sequencer.
package trace_pkg;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_R   = 8'h52;
    localparam logic [7:0] ASCII_LR  = 8'h72;
    localparam logic [7:0] ASCII_W   = 8'h57;
    localparam logic [7:0] ASCII_LW  = 8'h77;

    typedef enum logic [1:0] {
        ST_OP,
        ST_SEP,
        ST_HEX,
        ST_SKIP
    } parse_state_t;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == ASCII_SP) || (c == ASCII_TAB);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == ASCII_R) || (c == ASCII_LR) || (c == ASCII_W) || (c == ASCII_LW);
    endfunction

    function automatic logic is_write(input logic [7:0] c);
        return (c == ASCII_W) || (c == ASCII_LW);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // 'A'/'a' have low nibble 1, so letters map to low nibble + 9.
    function automatic logic [3:0] ascii_to_nibble(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end
        return c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous request FIFO with wrap-bit pointers; head is read straight from storage.
module trace_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_empty_nx,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_nx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_count_nx = w_count + CW'(w_do_push) - CW'(w_do_pop);
    assign o_empty_nx = (w_count_nx == '0);
    assign o_head     = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update.
    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // Entry storage.
    // NOTE: storage is not reset; stale contents are unreachable because the consumer masks the head with empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/trace_req_sequencer.sv
// Parses "<op> <hex addr>" trace lines into queued cache requests with status flags.
module trace_req_sequencer
    import trace_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_en,
    input  logic [7:0]        in_byte,
    input  logic              in_eof,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [15:0]       req_count,
    output logic              overflow,
    output logic              line_err,
    output logic              done
);

    localparam int MAX_DIGITS = ADDR_W / 4;
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

    parse_state_t      r_state, w_state_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_acc, w_acc_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic              r_tail, w_tail_nx;
    logic              r_eof, w_eof_nx;
    logic              w_push;
    logic              w_err;
    logic              r_overflow, r_line_err, r_done;
    logic [15:0]       r_req_count;

    logic              w_full, w_empty, w_empty_nx, w_pop, w_drop;
    logic [ADDR_W:0]   w_head;
    logic [3:0]        w_nib;

    assign w_nib = ascii_to_nibble(in_byte);

    // Parser next state: the byte is handled first, then EOF is folded in.
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nx = r_state;
        w_we_nx    = r_we;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_tail_nx  = r_tail;
        w_eof_nx   = r_eof;
        w_push     = 1'b0;
        w_err      = 1'b0;
        if (!r_eof) begin
            if (in_en && (in_byte != ASCII_CR)) begin
                unique case (r_state)
                    ST_OP: begin
                        if (is_op(in_byte)) begin
                            w_state_nx = ST_SEP;
                            w_we_nx    = is_write(in_byte);
                            w_acc_nx   = '0;
                            w_cnt_nx   = '0;
                            w_tail_nx  = 1'b0;
                        end else if (!(in_byte == ASCII_LF || is_ws(in_byte))) begin
                            w_state_nx = ST_SKIP;
                            w_err      = 1'b1;
                        end
                    end
                    ST_SEP: begin
                        if (is_hex(in_byte)) begin
                            w_state_nx = ST_HEX;
                            w_acc_nx   = {{(ADDR_W-4){1'b0}}, w_nib};
                            w_cnt_nx   = CNT_W'(1);
                        end else if (in_byte == ASCII_LF) begin
                            w_state_nx = ST_OP;
                            w_err      = 1'b1;
                        end else if (!is_ws(in_byte)) begin
                            w_state_nx = ST_SKIP;
                            w_err      = 1'b1;
                        end
                    end
                    ST_HEX: begin
                        if (is_hex(in_byte) && !r_tail) begin
                            if (r_cnt == CNT_W'(MAX_DIGITS)) begin
                                w_state_nx = ST_SKIP;
                                w_err      = 1'b1;
                            end else begin
                                w_acc_nx = {r_acc[ADDR_W-5:0], w_nib};
                                w_cnt_nx = r_cnt + CNT_W'(1);
                            end
                        end else if (in_byte == ASCII_LF) begin
                            w_state_nx = ST_OP;
                            w_push     = 1'b1;
                        end else if (is_ws(in_byte)) begin
                            w_tail_nx = 1'b1;
                        end else begin
                            w_state_nx = ST_SKIP;
                            w_err      = 1'b1;
                        end
                    end
                    ST_SKIP: begin
                        if (in_byte == ASCII_LF) w_state_nx = ST_OP;
                    end
                    default: w_state_nx = ST_OP;
                endcase
            end
            if (in_eof) begin
                if ((w_state_nx == ST_HEX) && (w_cnt_nx != '0)) w_push = 1'b1;
                w_state_nx = ST_OP;
                w_eof_nx   = 1'b1;
            end
        end
    end

    // Parser and line accumulator registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_OP;
            r_we    <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_tail  <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_we    <= w_we_nx;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_cnt_nx;
            r_tail  <= w_tail_nx;
            r_eof   <= w_eof_nx;
        end
    end

    trace_fifo #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_push),
        .i_data     ({w_we_nx, w_acc_nx}),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_empty_nx (w_empty_nx),
        .o_head     (w_head)
    );

    assign w_pop  = req_valid & req_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    // Sticky flags, saturating handshake counter and completion flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_line_err  <= 1'b0;
            r_done      <= 1'b0;
            r_req_count <= '0;
        end else begin
            r_overflow <= r_overflow | w_drop;
            r_line_err <= r_line_err | w_err;
            r_done     <= r_done | (w_eof_nx & w_empty_nx & (w_state_nx == ST_OP));
            if (w_pop && (r_req_count != 16'hFFFF)) r_req_count <= r_req_count + 16'd1;
        end
    end

    assign req_valid = ~w_empty;
    assign req_we    = w_head[ADDR_W] & ~w_empty;
    assign req_addr  = w_head[ADDR_W-1:0] & {ADDR_W{~w_empty}};
    assign req_count = r_req_count;
    assign overflow  = r_overflow;
    assign line_err  = r_line_err;
    assign done      = r_done;

endmodule

// File: tb/tb_trace_req_sequencer.sv
// Random and directed trace streams checked cycle by cycle against a line-level reference model.
module tb_trace_req_sequencer;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_en = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_eof = 1'b0;
    logic              req_ready = 1'b0;
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_count;
    logic              overflow;
    logic              line_err;
    logic              done;

    always #5 clk = ~clk;

    trace_req_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_en     (in_en),
        .in_byte   (in_byte),
        .in_eof    (in_eof),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_count (req_count),
        .overflow  (overflow),
        .line_err  (line_err),
        .done      (done)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
    } req_t;

    req_t        m_q[$];
    logic [7:0]  m_line[$];
    bit          m_eof, m_done, m_ovf, m_err;
    int          m_cnt;
    int          g_rdy_pct = 100;
    logic [7:0]  g_tx[$];

    function automatic bit m_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09);
    endfunction

    function automatic int m_hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
        return -1;
    endfunction

    // Judge a whole line: [ws] op [ws] 1..8 hex [ws], then end of line.
    function automatic void eval_line(input bit lf, output bit commit, output bit we,
                                      output logic [31:0] addr, output bit err);
        int n = m_line.size();
        int i = 0;
        int nd = 0;
        logic [7:0] c;
        commit = 0; we = 0; addr = 0; err = 0;
        while (i < n && m_ws(m_line[i])) i++;
        if (i == n) return;
        c = m_line[i];
        if (!(c == "R" || c == "r" || c == "W" || c == "w")) begin err = 1; return; end
        we = (c == "W" || c == "w");
        i++;
        while (i < n && m_ws(m_line[i])) i++;
        while (i < n && m_hexval(m_line[i]) >= 0) begin
            if (nd == ADDR_W / 4) begin err = 1; return; end
            addr = addr * 16 + 32'(m_hexval(m_line[i]));
            nd++;
            i++;
        end
        if (nd == 0) begin err = (i < n) || lf; return; end
        while (i < n && m_ws(m_line[i])) i++;
        if (i < n) begin err = 1; return; end
        commit = 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_line.delete();
        m_eof = 0; m_done = 0; m_ovf = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] b, input bit eof, input bit rdy);
        bit   pop = (m_q.size() != 0) && rdy;
        bit   commit = 0, c2, e;
        req_t r, r2;
        if (!m_eof) begin
            if (en && b != 8'h0D) begin
                if (b == 8'h0A) begin
                    eval_line(1'b1, commit, r.we, r.addr, e);
                    if (e) m_err = 1;
                    m_line.delete();
                end else begin
                    m_line.push_back(b);
                end
            end
            if (eof) begin
                eval_line(1'b0, c2, r2.we, r2.addr, e);
                if (e) m_err = 1;
                if (c2) begin commit = 1; r = r2; end
                m_line.delete();
                m_eof = 1;
            end
        end
        if (pop) begin
            void'(m_q.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        if (commit) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back(r);
        end
        if (m_eof && m_q.size() == 0) m_done = 1;
    endtask

    task automatic compare_all();
        check("req_valid", req_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("req_we", req_we, m_q[0].we);
            check("req_addr", req_addr, m_q[0].addr);
        end
        check("req_count", req_count, m_cnt);
        check("overflow", overflow, m_ovf);
        check("done", done, m_done);
        if (m_line.size() == 0) check("line_err", line_err, m_err);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit en, input logic [7:0] b, input bit eof);
        bit rdy = ($urandom_range(99) < g_rdy_pct);
        in_en = en; in_byte = en ? b : 8'h00; in_eof = eof; req_ready = rdy;
        @(posedge clk);
        model_step(en, b, eof, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_tx(input bit eof_on_last);
        for (int i = 0; i < g_tx.size(); i++) begin
            if ($urandom_range(3) == 0) cycle(1'b0, 8'h00, 1'b0);
            cycle(1'b1, g_tx[i], eof_on_last && (i == g_tx.size() - 1));
        end
        g_tx.delete();
    endtask

    task automatic feed_str(input string s, input bit eof_on_last);
        for (int i = 0; i < s.len(); i++) g_tx.push_back(s[i]);
        send_tx(eof_on_last);
    endtask

    task automatic tx_ws(input int n);
        for (int i = 0; i < n; i++) g_tx.push_back($urandom_range(1) ? 8'h20 : 8'h09);
    endtask

    task automatic tx_digits(input int n);
        for (int i = 0; i < n; i++) begin
            int v = $urandom_range(15);
            if (v < 10) g_tx.push_back(8'(48 + v));
            else g_tx.push_back(8'(($urandom_range(1) ? 65 : 97) + v - 10));
        end
    endtask

    task automatic tx_op();
        int k = $urandom_range(3);
        g_tx.push_back(k == 0 ? "R" : k == 1 ? "r" : k == 2 ? "W" : "w");
    endtask

    task automatic gen_line();
        int kind = $urandom_range(11);
        case (kind)
            0: tx_ws($urandom_range(2));
            1: begin g_tx.push_back("X"); tx_ws(1); tx_digits(2); end
            2: begin tx_op(); tx_ws(1); tx_digits(9); end
            3: begin tx_op(); tx_ws($urandom_range(2)); end
            4: begin tx_op(); tx_ws(1); tx_digits(2); g_tx.push_back("z"); end
            5: begin tx_op(); tx_ws(1); tx_digits(2); tx_ws(1); tx_digits(1); end
            default: begin
                tx_ws($urandom_range(1));
                tx_op();
                tx_ws($urandom_range(1, 3));
                tx_digits($urandom_range(1, 8));
                tx_ws($urandom_range(2));
            end
        endcase
        if ($urandom_range(2) == 0) g_tx.push_back(8'h0D);
        g_tx.push_back(8'h0A);
        send_tx(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, req_valid, 0);
        check({tag, "_we"}, req_we, 0);
        check({tag, "_addr"}, req_addr, 0);
        check({tag, "_count"}, req_count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_err"}, line_err, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset(input string tag);
        in_en = 0; in_eof = 0; req_ready = 0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic drain();
        g_rdy_pct = 100;
        for (int i = 0; i < 4 * DEPTH && m_q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b0);
        idle(2);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single read, consumer always ready.
        g_rdy_pct = 100;
        feed_str("R 1a2b3c4d\n", 1'b0);
        idle(3);

        // Write with CR, malformed op, address-less line, then recovery.
        feed_str("w FF", 1'b0);
        g_tx.push_back(8'h0D);
        send_tx(1'b0);
        feed_str("\nX 12\nR\nR 5\n", 1'b0);
        idle(3);
        check("err_sticky", line_err, 1);

        // Overflow: DEPTH+1 lines while the consumer stalls.
        g_rdy_pct = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            g_tx.push_back("W"); g_tx.push_back(" "); g_tx.push_back(8'(48 + i)); g_tx.push_back(8'h0A);
            send_tx(1'b0);
        end
        check("ovf_burst", overflow, 1);
        drain();

        // Too many digits.
        feed_str("R 123456789\n", 1'b0);
        idle(2);

        // Unterminated last line committed by EOF.
        feed_str("W 7", 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        drain();
        check("done_eof", done, 1);
        feed_str("R 9\n", 1'b0);
        check("ignored_after_eof", req_valid, 0);

        // Reset mid-line with queued entries.
        do_reset("rst_eof");
        g_rdy_pct = 0;
        feed_str("R 1\nW 2\nr 3\nR 4", 1'b0);
        do_reset("rst_mid");
        g_rdy_pct = 100;
        feed_str("r 0\n", 1'b0);
        idle(2);

        // Random traffic with varying back-pressure; last byte shares the EOF cycle.
        do_reset("rst_rand");
        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 0) g_rdy_pct = $urandom_range(0, 100);
            gen_line();
        end
        feed_str("W abc", 1'b1);
        drain();
        check("done_final", done, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
